// File: rtl/pmc_shift_sequencer.sv
// pmc_shift_sequencer
//   Serial configuration/readout sequencer for the pixel matrix chain.
//   On an accepted start it snapshots the dout lane words and shifts up to
//   WORD_W bits per lane out on matrix_dout, MSB of the selected range first.
//   At the same time it captures matrix_din into din_words. It generates
//   clkSh, shA/shB and an optional write_cfg pulse with HALF_CYC phase timing.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   start           1-cycle request, accepted only while idle
//   abort           return to idle on the next cycle, no done pulse
//   shift_len       bits per lane; 0 or >WORD_W means WORD_W
//   sel_b           0: shA asserted during the sequence, 1: shB
//   wcfg_en         pulse write_cfg after the last shift
//   dout_words      lane j = [j*WORD_W +: WORD_W], sampled at start
//   din_words       captured lane data, lane j = [j*WORD_W +: WORD_W]
//   matrix_dout     serial data to the matrix
//   matrix_din      serial data from the matrix
//   clkSh           shift clock to the matrix
//   shA, shB        shift-chain select
//   write_cfg       configuration latch pulse
//   busy            sequence in progress
//   done            1-cycle pulse on normal completion
module pmc_shift_sequencer #(
    parameter int unsigned LANES    = 16,
    parameter int unsigned WORD_W   = 32,
    parameter int unsigned HALF_CYC = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [5:0]              shift_len,
    input  logic                    sel_b,
    input  logic                    wcfg_en,
    input  logic [LANES*WORD_W-1:0] dout_words,
    output logic [LANES*WORD_W-1:0] din_words,
    output logic [LANES-1:0]        matrix_dout,
    input  logic [LANES-1:0]        matrix_din,
    output logic                    clkSh,
    output logic                    shA,
    output logic                    shB,
    output logic                    write_cfg,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned CNT_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int unsigned PH_W    = $clog2(HALF_CYC + 1);
    localparam logic [5:0]  MAX_LEN = 6'(WORD_W);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_CLK_HI,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [PH_W-1:0]         ph_q, ph_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [LANES*WORD_W-1:0] snap_q, snap_d;
    logic [LANES*WORD_W-1:0] din_q, din_d;
    logic                    sel_q, sel_d;
    logic                    wen_q, wen_d;
    logic [LANES-1:0]        mdout_q, mdout_d;
    logic                    clksh_q, clksh_d;
    logic                    sha_q, sha_d;
    logic                    shb_q, shb_d;
    logic                    wrcfg_q, wrcfg_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    phase_end;
    logic [5:0]              len_v;
    logic [WORD_W-1:0]       lane_w;

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q + 1'b1;
        cnt_d     = cnt_q;
        snap_d    = snap_q;
        din_d     = din_q;
        sel_d     = sel_q;
        wen_d     = wen_q;
        len_v     = '0;
        lane_w    = '0;
        phase_end = (ph_q == PH_LAST);

        case (state_q)
            S_IDLE: begin
                ph_d = '0;
                if (start && !abort) begin
                    snap_d  = dout_words;
                    len_v   = (shift_len == 6'd0 || shift_len > MAX_LEN) ? MAX_LEN : shift_len;
                    cnt_d   = CNT_W'(len_v - 6'd1);
                    sel_d   = sel_b;
                    wen_d   = wcfg_en;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (phase_end) begin
                    ph_d    = '0;
                    state_d = S_CLK_HI;
                end
            end
            S_CLK_HI: begin
                if (phase_end) begin
                    ph_d = '0;
                    for (int unsigned j = 0; j < LANES; j++) begin
                        din_d[j*WORD_W +: WORD_W] = {din_q[j*WORD_W +: WORD_W-1], matrix_din[j]};
                    end
                    if (cnt_q == '0) begin
                        state_d = wen_q ? S_WRITE : S_DONE;
                    end else begin
                        cnt_d   = cnt_q - 1'b1;
                        state_d = S_SETUP;
                    end
                end
            end
            S_WRITE: begin
                if (phase_end) begin
                    ph_d    = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                ph_d    = '0;
                state_d = S_IDLE;
            end
            default: begin
                ph_d    = '0;
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides every transition, including the capture on the
        // final clkSh-high cycle, so din_words keeps only completed shifts.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            ph_d    = '0;
            din_d   = din_q;
        end

        // Outputs are decoded from the next state and registered, so every
        // pin changes exactly on a clock edge with no decode glitches.
        clksh_d = (state_d == S_CLK_HI);
        wrcfg_d = (state_d == S_WRITE);
        busy_d  = (state_d == S_SETUP) || (state_d == S_CLK_HI) || (state_d == S_WRITE);
        done_d  = (state_d == S_DONE);
        sha_d   = busy_d & ~sel_d;
        shb_d   = busy_d & sel_d;
        mdout_d = '0;
        if (state_d == S_SETUP || state_d == S_CLK_HI) begin
            for (int unsigned j = 0; j < LANES; j++) begin
                lane_w     = snap_d[j*WORD_W +: WORD_W];
                mdout_d[j] = lane_w[cnt_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ph_q    <= '0;
            cnt_q   <= '0;
            snap_q  <= '0;
            din_q   <= '0;
            sel_q   <= 1'b0;
            wen_q   <= 1'b0;
            mdout_q <= '0;
            clksh_q <= 1'b0;
            sha_q   <= 1'b0;
            shb_q   <= 1'b0;
            wrcfg_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            din_q   <= din_d;
            sel_q   <= sel_d;
            wen_q   <= wen_d;
            mdout_q <= mdout_d;
            clksh_q <= clksh_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            wrcfg_q <= wrcfg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign din_words   = din_q;
    assign matrix_dout = mdout_q;
    assign clkSh       = clksh_q;
    assign shA         = sha_q;
    assign shB         = shb_q;
    assign write_cfg   = wrcfg_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_pmc_shift_sequencer.sv
// Directed bench for pmc_shift_sequencer with matrix_din looped back from
// matrix_dout. Cycle numbers count the start cycle as cycle 1.
module tb_pmc_shift_sequencer;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [5:0]    shift_len;
    logic          sel_b;
    logic          wcfg_en;
    logic [511:0]  dout_words;
    logic [511:0]  din_words;
    logic [15:0]   matrix_dout;
    logic [15:0]   matrix_din;
    logic          clkSh, shA, shB, write_cfg, busy, done;

    int            vectors = 0;
    int            miscompares = 0;

    int            cyc, rises, wc_cnt, wc_first, sh_bad, done_cnt;
    logic          done_seen, prev_clk, exp_sel;
    logic [31:0]   pat;

    assign matrix_din = matrix_dout;

    always #5 clk = ~clk;

    pmc_shift_sequencer #(.LANES(16), .WORD_W(32), .HALF_CYC(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .shift_len  (shift_len),
        .sel_b      (sel_b),
        .wcfg_en    (wcfg_en),
        .dout_words (dout_words),
        .din_words  (din_words),
        .matrix_dout(matrix_dout),
        .matrix_din (matrix_din),
        .clkSh      (clkSh),
        .shA        (shA),
        .shB        (shB),
        .write_cfg  (write_cfg),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts a sequence and tracks it at each negedge until done or budget.
    // A nonzero restart_at re-pulses start (with altered inputs) at that cycle.
    task automatic run(input int budget, input int lane, input int restart_at);
        rises = 0; wc_cnt = 0; wc_first = 0; sh_bad = 0; pat = '0;
        done_seen = 1'b0; prev_clk = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc <= budget) begin
            if (restart_at != 0 && cyc == restart_at) begin
                start      = 1'b1;
                dout_words = ~dout_words;
                shift_len  = 6'd32;
            end else begin
                start = 1'b0;
            end
            if (clkSh && !prev_clk) begin
                rises++;
                pat = {pat[30:0], matrix_dout[lane]};
            end
            prev_clk = clkSh;
            if (write_cfg) begin
                if (wc_cnt == 0) wc_first = cyc;
                wc_cnt++;
            end
            if (busy && (shA !== !exp_sel || shB !== exp_sel)) sh_bad++;
            if (clkSh && write_cfg) sh_bad++;
            if (done) begin
                done_seen = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic count_done(input int n);
        done_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; shift_len = '0;
        sel_b = 1'b0; wcfg_en = 1'b0; dout_words = '0; exp_sel = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ctrl", {26'd0, clkSh, shA, shB, write_cfg, busy, done}, 32'd0);
        check("rst_din", {31'd0, |din_words}, 32'd0);
        check("rst_mdout", {16'd0, matrix_dout}, 32'd0);

        // Full 32-bit shift, shA, no write_cfg.
        dout_words[0*32 +: 32] = 32'hA5A5_0001;
        dout_words[5*32 +: 32] = 32'h1234_5678;
        shift_len = 6'd32; sel_b = 1'b0; wcfg_en = 1'b0; exp_sel = 1'b0;
        run(200, 0, 0);
        check("t1_done_seen", {31'd0, done_seen}, 32'd1);
        check("t1_latency", cyc + 1, 32'd130);
        check("t1_rises", rises, 32'd32);
        check("t1_pattern", pat, 32'hA5A5_0001);
        check("t1_sh_sel", sh_bad, 32'd0);
        check("t1_no_wcfg", wc_cnt, 32'd0);
        check("t1_din0", din_words[0*32 +: 32], 32'hA5A5_0001);
        check("t1_din5", din_words[5*32 +: 32], 32'h1234_5678);
        check("t1_done_idle", {27'd0, busy, shA, shB, clkSh, write_cfg}, 32'd0);
        check("t1_done_mdout", {16'd0, matrix_dout}, 32'd0);

        // Short shift with shB and write_cfg; lane0 shows prior bits moving up.
        dout_words = '0;
        dout_words[0*32 +: 32] = 32'h0000_0005;
        dout_words[3*32 +: 32] = 32'h0000_000B;
        shift_len = 6'd4; sel_b = 1'b1; wcfg_en = 1'b1; exp_sel = 1'b1;
        run(60, 3, 0);
        check("t2_done_seen", {31'd0, done_seen}, 32'd1);
        check("t2_latency", cyc + 1, 32'd20);
        check("t2_rises", rises, 32'd4);
        check("t2_pattern", pat, 32'h0000_000B);
        check("t2_sh_sel", sh_bad, 32'd0);
        check("t2_wcfg_len", wc_cnt, 32'd2);
        check("t2_wcfg_first", wc_first, 32'd17);
        check("t2_din3", din_words[3*32 +: 32], 32'h0000_000B);
        check("t2_din0", din_words[0*32 +: 32], 32'h5A50_0015);

        // Out-of-range lengths clamp to 32.
        dout_words = '0; sel_b = 1'b0; wcfg_en = 1'b0; exp_sel = 1'b0;
        shift_len = 6'd0;
        run(200, 0, 0);
        check("t3_len0_rises", rises, 32'd32);
        check("t3_len0_latency", cyc + 1, 32'd130);
        shift_len = 6'd40;
        run(200, 0, 0);
        check("t3_len40_rises", rises, 32'd32);
        check("t3_len40_latency", cyc + 1, 32'd130);

        // Start while busy and start during the done cycle are both ignored.
        dout_words = '0;
        dout_words[1*32 +: 32] = 32'h0000_00C3;
        shift_len = 6'd8;
        run(100, 1, 5);
        check("t4_latency", cyc + 1, 32'd34);
        check("t4_rises", rises, 32'd8);
        check("t4_din1", din_words[1*32 +: 32], 32'h0000_00C3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t4_start_in_done", {30'd0, busy, done}, 32'd0);
        count_done(10);
        check("t4_single_done", done_cnt, 32'd0);
        check("t4_idle_busy", {31'd0, busy}, 32'd0);

        // Abort during the third clkSh-high phase.
        dout_words = '0;
        dout_words[2*32 +: 32] = 32'hC000_0000;
        shift_len = 6'd32; sel_b = 1'b0; wcfg_en = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rises = 0; prev_clk = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            if (clkSh && !prev_clk) rises++;
            prev_clk = clkSh;
            if (c < 11) @(negedge clk);
        end
        check("t5_rises_before", rises, 32'd3);
        check("t5_in_hi", {31'd0, clkSh}, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5_abort_ctrl", {26'd0, clkSh, shA, shB, write_cfg, busy, done}, 32'd0);
        check("t5_abort_mdout", {16'd0, matrix_dout}, 32'd0);
        count_done(10);
        check("t5_no_done", done_cnt, 32'd0);
        check("t5_partial_din2", din_words[2*32 +: 32], 32'h0000_0003);
        dout_words[2*32 +: 32] = 32'h0000_0002;
        shift_len = 6'd2; sel_b = 1'b1; wcfg_en = 1'b1; exp_sel = 1'b1;
        run(40, 2, 0);
        check("t5_restart_latency", cyc + 1, 32'd12);
        check("t5_restart_din2", din_words[2*32 +: 32], 32'h0000_000E);
        check("t5_restart_sh_sel", sh_bad, 32'd0);

        // Synchronous reset in the middle of a setup phase.
        dout_words = '0;
        dout_words[0*32 +: 32] = 32'hFFFF_FFFF;
        shift_len = 6'd32; sel_b = 1'b0; wcfg_en = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("t6_in_setup", {30'd0, busy, clkSh}, 32'd2);
        check("t6_partial_din0", din_words[0*32 +: 32], 32'h0000_0003);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_ctrl", {26'd0, clkSh, shA, shB, write_cfg, busy, done}, 32'd0);
        check("t6_rst_mdout", {16'd0, matrix_dout}, 32'd0);
        check("t6_rst_din", {31'd0, |din_words}, 32'd0);
        count_done(10);
        check("t6_no_done", done_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
